// File: rtl/trng_arbiter.sv
// ----------------------------------------------------------------------------
// trng_arbiter
//   Shares one hardened TRNG between NUM_REQ crypto clients. Clients are
//   granted round-robin. The TRNG is driven through a level request/ready
//   handshake. Each collected word is health checked, with a bounded number
//   of retries. Exactly one 32-bit word (or an error) is returned per grant.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req[N]         level request per client, held high until ack
//   ack[N]         client consumed its response (only ack[grant] matters)
//   rsp_valid[N]   one-hot response valid for the granted client
//   rsp_data[32]   random word, forced to 0 whenever rsp_err is set
//   rsp_err        word failed health check or the TRNG timed out
//   trng_request   level request to the TRNG
//   trng_ready     TRNG word available
//   trng_data[32]  TRNG word
//   busy           arbiter is not idle
//   fail_count[8]  saturating count of health failures and timeouts
// ----------------------------------------------------------------------------
module trng_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 128,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               trng_request,
    input  logic               trng_ready,
    input  logic [31:0]        trng_data,
    output logic               busy,
    output logic [7:0]         fail_count
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRY - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, RELEASE, DELIVER} state_t;

    state_t            state, next_state;
    logic [GW-1:0]     grant, last_grant, rr_pick, rr_idx;
    logic              rr_found;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     retry;
    logic [31:0]       word, prev_word;
    logic              prev_valid, fault, abandon;
    logic              grant_req, timed_out, health_fail, retry_left, release_abandon;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic              trng_request_d, busy_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign grant_req       = req[grant];
    // Last COLLECT cycle: the request has then been high for TIMEOUT cycles.
    assign timed_out       = (timer == TW'(TIMEOUT - 1));
    // A repeat of the previously delivered word suggests a stuck source.
    assign health_fail     = (word == 32'h0000_0000) || (word == 32'hFFFF_FFFF) ||
                             (prev_valid && (word == prev_word));
    assign retry_left      = (retry < LAST_RETRY);
    assign release_abandon = abandon || !grant_req;

    // Round-robin search starting just after the last served client.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = GW'((int'(last_grant) + i) % NUM_REQ);
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A new TRNG request is only raised once trng_ready has returned low,
    // so every word is a fresh accumulation.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req && !trng_ready) next_state = COLLECT;
            COLLECT: if (!grant_req || trng_ready || timed_out) next_state = RELEASE;
            RELEASE: begin
                if (!trng_ready) begin
                    if (release_abandon)             next_state = IDLE;
                    else if (fault)                  next_state = DELIVER;
                    else if (health_fail && retry_left) next_state = COLLECT;
                    else                             next_state = DELIVER;
                end
            end
            DELIVER: if (ack[grant] || !grant_req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        trng_request_d = (next_state == COLLECT);
        busy_d         = (next_state != IDLE);
        rsp_valid_d    = '0;
        if (next_state == DELIVER) rsp_valid_d = NUM_REQ'(1) << grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= '0;
            trng_request <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rsp_valid    <= rsp_valid_d;
            trng_request <= trng_request_d;
            busy         <= busy_d;
        end
    end

    // Datapath: grant bookkeeping, timer, retry, health history and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            timer      <= '0;
            retry      <= '0;
            word       <= '0;
            prev_word  <= '0;
            prev_valid <= 1'b0;
            fault      <= 1'b0;
            abandon    <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            fail_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_state == COLLECT) begin
                        grant   <= rr_pick;
                        timer   <= '0;
                        retry   <= '0;
                        fault   <= 1'b0;
                        abandon <= 1'b0;
                    end
                end
                COLLECT: begin
                    timer <= timer + TW'(1);
                    if (!grant_req) begin
                        abandon <= 1'b1;
                    end else if (trng_ready) begin
                        word <= trng_data;
                    end else if (timed_out) begin
                        fault      <= 1'b1;
                        fail_count <= sat_inc(fail_count);
                    end
                end
                RELEASE: begin
                    if (!grant_req) abandon <= 1'b1;
                    if (!trng_ready) begin
                        if (release_abandon) begin
                            last_grant <= grant;
                        end else if (fault) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end else if (health_fail) begin
                            fail_count <= sat_inc(fail_count);
                            retry      <= retry + RW'(1);
                            if (retry_left) begin
                                timer <= '0;
                            end else begin
                                rsp_err  <= 1'b1;
                                rsp_data <= '0;
                            end
                        end else begin
                            prev_word  <= word;
                            prev_valid <= 1'b1;
                            rsp_data   <= word;
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                DELIVER: begin
                    if (ack[grant] || !grant_req) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// ----------------------------------------------------------------------------
// tb_trng_arbiter
//   Self-checking bench for trng_arbiter. A behavioural TRNG supplies words
//   from a queue after a programmable delay. A reference model tracks the
//   round-robin order, health rules and fail count at transaction level.
// ----------------------------------------------------------------------------
module tb_trng_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int TIMEOUT   = 128;
    localparam int MAX_RETRY = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               trng_request;
    logic               trng_ready = 1'b0;
    logic [31:0]        trng_data  = 32'h0;
    logic               busy;
    logic [7:0]         fail_count;

    int checks   = 0;
    int failures = 0;

    // TRNG model state
    int          trng_delay  = 32;
    bit          never_ready = 1'b0;
    int          trng_cnt    = 0;
    logic [31:0] trng_q[$];

    // Reference model state
    logic [31:0] plan_q[$];
    int          m_last;
    logic [31:0] m_prev_word;
    bit          m_prev_valid;
    int          m_fail;

    trng_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .trng_request(trng_request),
        .trng_ready  (trng_ready),
        .trng_data   (trng_data),
        .busy        (busy),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    // Level-handshake TRNG: ready rises trng_delay cycles into a request and
    // stays high until the request drops.
    always @(negedge clk) begin
        if (!rst_n || !trng_request) begin
            trng_ready = 1'b0;
            trng_cnt   = 0;
        end else if (!trng_ready && !never_ready) begin
            trng_cnt++;
            if (trng_cnt >= trng_delay) begin
                if (trng_q.size() > 0) trng_data = trng_q.pop_front();
                else                   trng_data = 32'hDEAD_0001;
                trng_ready = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
        req = mask;
    endtask

    function automatic bit isBad(input logic [31:0] w);
        return (w == 32'h0) || (w == 32'hFFFF_FFFF) || (m_prev_valid && w == m_prev_word);
    endfunction

    function automatic int rrPick(input logic [NUM_REQ-1:0] mask);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (mask[(m_last + i) % NUM_REQ]) return (m_last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] goodWord();
        logic [31:0] w;
        w = $urandom;
        while (isBad(w)) w = $urandom;
        return w;
    endfunction

    function automatic logic [31:0] randWord();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)                      return 32'h0;
        else if (sel == 1)                 return 32'hFFFF_FFFF;
        else if (sel == 2 && m_prev_valid) return m_prev_word;
        return $urandom;
    endfunction

    task automatic pushWord(input logic [31:0] w);
        trng_q.push_back(w);
        plan_q.push_back(w);
    endtask

    // One grant: up to MAX_RETRY words, first healthy one is delivered.
    task automatic predict(output logic [31:0] exp_d, output logic exp_e);
        logic [31:0] w;
        bit done;
        exp_d = 32'h0;
        exp_e = 1'b1;
        done  = 1'b0;
        for (int r = 0; r < MAX_RETRY; r++) begin
            if (!done && plan_q.size() > 0) begin
                w = plan_q.pop_front();
                if (isBad(w)) begin
                    if (m_fail < 255) m_fail++;
                end else begin
                    m_prev_word  = w;
                    m_prev_valid = 1'b1;
                    exp_d = w;
                    exp_e = 1'b0;
                    done  = 1'b1;
                end
            end
        end
    endtask

    task automatic modelReset();
        m_last       = NUM_REQ - 1;
        m_prev_word  = 32'h0;
        m_prev_valid = 1'b0;
        m_fail       = 0;
        trng_q.delete();
        plan_q.delete();
    endtask

    task automatic serveOne(input int c, input logic [31:0] exp_d, input logic exp_e);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("rsp_seen", 32'(rsp_valid != '0), 32'd1);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << c);
        checkOutput("rsp_data", rsp_data, exp_d);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_e));
        checkOutput("fail_count", 32'(fail_count), 32'(m_fail));
        checkOutput("busy_deliver", 32'(busy), 32'd1);
        ack[c] = 1'b1;
        req[c] = 1'b0;
        tick();
        ack = '0;
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        checkOutput("busy_after_ack", 32'(busy), 32'd0);
        m_last = c;
    endtask

    initial begin
        logic [31:0] d, x;
        logic        e;
        logic [NUM_REQ-1:0] pending;
        int n, c;
        bit saw_valid;

        rst_n = 1'b0;
        req   = '0;
        ack   = '0;
        modelReset();
        tick(); tick();
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_trng_request", 32'(trng_request), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fail_count", 32'(fail_count), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single request, fixed word");
        trng_delay = 32;
        pushWord(32'hA5A5_1234);
        predict(d, e);
        applyStimulus(4'b0001);
        tick();
        checkOutput("t1_trng_request", 32'(trng_request), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        serveOne(0, d, e);
        checkOutput("t1_data_const", d, 32'hA5A5_1234);

        $display("[TB] round-robin order");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        modelReset();
        tick();
        trng_delay = 4;
        applyStimulus(4'b1010);
        pushWord(goodWord()); predict(d, e); serveOne(1, d, e);
        pushWord(goodWord()); predict(d, e); serveOne(3, d, e);
        applyStimulus(4'b1111);
        pushWord(goodWord()); predict(d, e); serveOne(0, d, e);
        pushWord(goodWord()); predict(d, e); serveOne(1, d, e);
        pushWord(goodWord()); predict(d, e); serveOne(2, d, e);
        req[0] = 1'b1;
        pushWord(goodWord()); predict(d, e); serveOne(3, d, e);
        pushWord(goodWord()); predict(d, e); serveOne(0, d, e);

        $display("[TB] health retries");
        pushWord(32'h0);
        pushWord(32'hFFFF_FFFF);
        pushWord(32'h1357_9BDF);
        predict(d, e);
        applyStimulus(4'b0001);
        serveOne(0, d, e);
        checkOutput("t3_data_const", d, 32'h1357_9BDF);
        checkOutput("t3_fail_const", 32'(fail_count), 32'd2);

        pushWord(32'h0); pushWord(32'h0); pushWord(32'h0);
        predict(d, e);
        applyStimulus(4'b0001);
        serveOne(0, d, e);
        checkOutput("t4_err_const", 32'(rsp_err), 32'd1);
        checkOutput("t4_fail_const", 32'(fail_count), 32'd5);

        x = goodWord();
        pushWord(x);
        predict(d, e);
        applyStimulus(4'b0010);
        serveOne(1, d, e);
        pushWord(x);
        pushWord(goodWord());
        predict(d, e);
        applyStimulus(4'b0100);
        serveOne(2, d, e);
        checkOutput("t4_repeat_fail_const", 32'(fail_count), 32'd6);

        $display("[TB] TRNG timeout");
        never_ready = 1'b1;
        applyStimulus(4'b0001);
        tick();
        n = 0;
        while (trng_request === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        checkOutput("t5_request_cycles", 32'(n), 32'(TIMEOUT));
        if (m_fail < 255) m_fail++;
        serveOne(0, 32'h0, 1'b1);
        never_ready = 1'b0;

        $display("[TB] abandon and reset mid-collect");
        trng_delay = 32;
        applyStimulus(4'b0100);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("t6_request_before_drop", 32'(trng_request), 32'd1);
        applyStimulus(4'b0000);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid != '0) saw_valid = 1'b1;
        end
        checkOutput("t6_no_rsp_valid", 32'(saw_valid), 32'd0);
        checkOutput("t6_trng_request", 32'(trng_request), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_fail_count", 32'(fail_count), 32'(m_fail));
        m_last = 2;

        applyStimulus(4'b1000);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t6_request_before_rst", 32'(trng_request), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t6_rst_rsp_data", rsp_data, 32'd0);
        checkOutput("t6_rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("t6_rst_trng_request", 32'(trng_request), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_fail_count", 32'(fail_count), 32'd0);
        applyStimulus(4'b0000);
        modelReset();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] randomized traffic");
        for (int it = 0; it < 20; it++) begin
            trng_delay = $urandom_range(1, 8);
            pending = NUM_REQ'($urandom_range(1, 15));
            applyStimulus(pending);
            while (pending != '0) begin
                c = rrPick(pending);
                while (plan_q.size() < MAX_RETRY) pushWord(randWord());
                predict(d, e);
                serveOne(c, d, e);
                pending[c] = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
